// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot sequencer.
//   boot_state_e   : sequencer FSM states
//   DATA_W         : program word width
//   END_MARKER_DEF : default stream word that terminates a load
package mips_boot_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] END_MARKER_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } boot_state_e;

endpackage

// File: rtl/mips_boot_sequencer_if.sv
// Program stream + instruction-memory write port of the boot sequencer.
//   in_valid / in_data / in_ready : program word stream (valid/ready)
//   instr_WE / instr_WA / instr_WD: instruction memory write port
// master = sequencer side, slave = program source / memory side.
interface mips_boot_sequencer_if
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              instr_WE;
  logic [ADDR_W-1:0] instr_WA;
  logic [DATA_W-1:0] instr_WD;

  modport master (
    input  in_valid, in_data,
    output in_ready, instr_WE, instr_WA, instr_WD
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, instr_WE, instr_WA, instr_WD
  );

endinterface

// File: rtl/mips_run_timer.sv
// Core run-length timer: counts enabled cycles from 0 after a clear and flags
// the cycle in which the count equals RUN_CYCLES-1 (never, when RUN_CYCLES=0).
//   clk, rst : clock, async active-high reset
//   en_i     : count this cycle
//   clr_i    : force count to 0 (has priority over en_i)
//   tc_o     : registered terminal-count flag, aligned with the counter value
module mips_run_timer #(
  parameter int unsigned RUN_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q,  tc_d;

  // Flag is computed from the next count so it is high in the same cycle the
  // counter holds LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tc_d = (RUN_CYCLES != 0) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mips_boot_sequencer.sv
// Boot/load controller for the MIPS single-cycle core: streams a program into
// instruction memory while holding the core in reset, then releases the core
// and optionally stops it after RUN_CYCLES cycles.
//   clk, rst   : clock, async active-high reset
//   start      : 1-cycle pulse, begin a (re)load (ignored while loading)
//   bus        : program stream in, instruction memory write port out
//   core_rstn  : core reset, active-low
//   running    : core released and counting
//   done       : RUN_CYCLES elapsed, core held out of reset but stopped
//   error      : last load was empty (end marker first)
//   word_count : words written in the last load
module mips_boot_sequencer
  import mips_boot_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [DATA_W-1:0] END_MARKER = END_MARKER_DEF,
  parameter int unsigned       RUN_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  mips_boot_sequencer_if.master bus,
  output logic                core_rstn,
  output logic                running,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     word_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << ADDR_W;

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              rstn_q, rstn_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic hs_c;
  logic marker_c;
  logic run_en_c;
  logic run_tc;

  assign hs_c     = (state_q == ST_LOAD) && bus.in_valid && ready_q;
  assign marker_c = (bus.in_data == END_MARKER);
  assign run_en_c = (state_q == ST_RUN);

  // Counter is held at 0 in every state but RUN, so each RUN entry restarts it.
  mips_run_timer #(
    .RUN_CYCLES (RUN_CYCLES)
  ) u_run_timer (
    .clk   (clk),
    .rst   (rst),
    .en_i  (run_en_c),
    .clr_i (!run_en_c),
    .tc_o  (run_tc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    error_d = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (hs_c) begin
          if (marker_c) begin
            if (cnt_q == '0) begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            we_d   = 1'b1;
            wa_d   = addr_q;
            wd_d   = bus.in_data;
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            // Memory full: stop before the address could wrap.
            if (cnt_q == FULL_COUNT - CNT_W'(1)) begin
              state_d = ST_RELEASE;
            end
          end
        end
      end

      // One cycle for the final write to commit before the core leaves reset.
      ST_RELEASE: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          error_d = 1'b0;
        end else if (run_tc) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // State-decoded outputs are registered from the next state.
    ready_d   = (state_d == ST_LOAD);
    rstn_d    = (state_d == ST_RUN) || (state_d == ST_DONE);
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      rstn_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      rstn_q    <= rstn_d;
      running_q <= running_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.instr_WE = we_q;
  assign bus.instr_WA = wa_q;
  assign bus.instr_WD = wd_q;
  assign core_rstn    = rstn_q;
  assign running      = running_q;
  assign done         = done_q;
  assign error        = error_q;
  assign word_count   = cnt_q;

endmodule

// File: tb/tb_mips_boot_sequencer.sv
// Directed, table-driven bench for mips_boot_sequencer. Two instances:
// dut_a (ADDR_W=8, RUN_CYCLES=50) and dut_b (ADDR_W=2, RUN_CYCLES=0).
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the following rising edge.
module tb_mips_boot_sequencer;

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        exp_ready;
    logic        exp_we;
    logic [7:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_rstn;
    logic        exp_run;
    logic        exp_done;
    logic        exp_err;
    logic [8:0]  exp_wc;
  } vec_t;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic rstn_a, running_a, done_a, error_a;
  logic rstn_b, running_b, done_b, error_b;
  logic [8:0] wc_a;
  logic [2:0] wc_b;

  int n_checks = 0;
  int n_fail   = 0;

  mips_boot_sequencer_if #(.ADDR_W(8)) bus_a ();
  mips_boot_sequencer_if #(.ADDR_W(2)) bus_b ();

  mips_boot_sequencer #(.ADDR_W(8), .END_MARKER(32'hFFFF_FFFF), .RUN_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .core_rstn(rstn_a), .running(running_a), .done(done_a), .error(error_a),
    .word_count(wc_a)
  );

  mips_boot_sequencer #(.ADDR_W(2), .END_MARKER(32'hFFFF_FFFF), .RUN_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .core_rstn(rstn_b), .running(running_b), .done(done_b), .error(error_b),
    .word_count(wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory models and write-pulse counters.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:3];
  int we_cnt_a = 0;
  int we_cnt_b = 0;

  always @(posedge clk) begin
    if (bus_a.instr_WE) begin
      mem_a[bus_a.instr_WA] <= bus_a.instr_WD;
      we_cnt_a <= we_cnt_a + 1;
    end
    if (bus_b.instr_WE) begin
      mem_b[bus_b.instr_WA] <= bus_b.instr_WD;
      we_cnt_b <= we_cnt_b + 1;
    end
  end

  function automatic vec_t mk(input logic st, input logic vl, input logic [31:0] d,
                              input logic rdy, input logic we, input logic [7:0] wa,
                              input logic [31:0] wd, input logic rn, input logic run,
                              input logic dn, input logic er, input logic [8:0] wc);
    vec_t v;
    v.start = st; v.valid = vl; v.data = d;
    v.exp_ready = rdy; v.exp_we = we; v.exp_wa = wa; v.exp_wd = wd;
    v.exp_rstn = rn; v.exp_run = run; v.exp_done = dn; v.exp_err = er; v.exp_wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input bit sel, input vec_t v, input string tag);
    logic ready, we, rn, run, dn, er;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [8:0]  wc;
    if (!sel) begin
      ready = bus_a.in_ready; we = bus_a.instr_WE; wa = bus_a.instr_WA;
      wd = bus_a.instr_WD; rn = rstn_a; run = running_a; dn = done_a;
      er = error_a; wc = wc_a;
    end else begin
      ready = bus_b.in_ready; we = bus_b.instr_WE; wa = 8'(bus_b.instr_WA);
      wd = bus_b.instr_WD; rn = rstn_b; run = running_b; dn = done_b;
      er = error_b; wc = 9'(wc_b);
    end
    chk({tag, ".in_ready"},   32'(ready), 32'(v.exp_ready));
    chk({tag, ".instr_WE"},   32'(we),    32'(v.exp_we));
    chk({tag, ".instr_WA"},   32'(wa),    32'(v.exp_wa));
    chk({tag, ".instr_WD"},   wd,         v.exp_wd);
    chk({tag, ".core_rstn"},  32'(rn),    32'(v.exp_rstn));
    chk({tag, ".running"},    32'(run),   32'(v.exp_run));
    chk({tag, ".done"},       32'(dn),    32'(v.exp_done));
    chk({tag, ".error"},      32'(er),    32'(v.exp_err));
    chk({tag, ".word_count"}, 32'(wc),    32'(v.exp_wc));
  endtask

  task automatic apply(input bit sel, input vec_t v, input string tag);
    @(negedge clk);
    if (!sel) begin
      start_a = v.start; bus_a.in_valid = v.valid; bus_a.in_data = v.data;
    end else begin
      start_b = v.start; bus_b.in_valid = v.valid; bus_b.in_data = v.data;
    end
    @(posedge clk);
    #1;
    check_vec(sel, v, tag);
  endtask

  // Hard stop in case a wait below is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ta[$];
    vec_t tb[$];
    vec_t tc[$];
    vec_t td[$];
    vec_t zero;
    int   run_cnt;
    bit   fell;

    zero = mk(0, 0, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 9'd0);

    // Load 3 words with gaps, a start while loading (ignored), then the marker.
    //         st vl data           rdy we wa     wd             rn run dn er wc
    ta.push_back(mk(1, 0, 32'h0,        1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 9'd0));
    ta.push_back(mk(0, 1, 32'h20080005, 1, 1, 8'h00, 32'h20080005, 0, 0, 0, 0, 9'd1));
    ta.push_back(mk(1, 0, 32'h0,        1, 0, 8'h00, 32'h20080005, 0, 0, 0, 0, 9'd1));
    ta.push_back(mk(0, 1, 32'h20090007, 1, 1, 8'h01, 32'h20090007, 0, 0, 0, 0, 9'd2));
    ta.push_back(mk(0, 1, 32'h01095020, 1, 1, 8'h02, 32'h01095020, 0, 0, 0, 0, 9'd3));
    ta.push_back(mk(0, 0, 32'h0,        1, 0, 8'h02, 32'h01095020, 0, 0, 0, 0, 9'd3));
    ta.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 8'h02, 32'h01095020, 0, 0, 0, 0, 9'd3));
    ta.push_back(mk(0, 1, 32'h12345678, 0, 0, 8'h02, 32'h01095020, 1, 1, 0, 0, 9'd3));

    // From DONE: empty load (error), ignored word in IDLE, then a partial load.
    tb.push_back(mk(1, 0, 32'h0,        1, 0, 8'h02, 32'h01095020, 0, 0, 0, 0, 9'd0));
    tb.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 8'h02, 32'h01095020, 0, 0, 0, 1, 9'd0));
    tb.push_back(mk(0, 1, 32'h11111111, 0, 0, 8'h02, 32'h01095020, 0, 0, 0, 1, 9'd0));
    tb.push_back(mk(1, 0, 32'h0,        1, 0, 8'h02, 32'h01095020, 0, 0, 0, 0, 9'd0));
    tb.push_back(mk(0, 1, 32'hAAAA0001, 1, 1, 8'h00, 32'hAAAA0001, 0, 0, 0, 0, 9'd1));
    tb.push_back(mk(0, 1, 32'hAAAA0002, 1, 1, 8'h01, 32'hAAAA0002, 0, 0, 0, 0, 9'd2));

    // After a mid-load reset: reload from 0, run, then start while running.
    tc.push_back(mk(1, 0, 32'h0,        1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 9'd0));
    tc.push_back(mk(0, 1, 32'hBBBB0001, 1, 1, 8'h00, 32'hBBBB0001, 0, 0, 0, 0, 9'd1));
    tc.push_back(mk(0, 0, 32'h0,        1, 0, 8'h00, 32'hBBBB0001, 0, 0, 0, 0, 9'd1));
    tc.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0, 8'h00, 32'hBBBB0001, 0, 0, 0, 0, 9'd1));
    tc.push_back(mk(0, 0, 32'h0,        0, 0, 8'h00, 32'hBBBB0001, 1, 1, 0, 0, 9'd1));
    tc.push_back(mk(1, 0, 32'h0,        1, 0, 8'h00, 32'hBBBB0001, 0, 0, 0, 0, 9'd0));

    // ADDR_W=2: four words fill memory and auto-release without a marker.
    td.push_back(mk(1, 0, 32'h0,        1, 0, 8'h00, 32'h0,        0, 0, 0, 0, 9'd0));
    td.push_back(mk(0, 1, 32'hC0000000, 1, 1, 8'h00, 32'hC0000000, 0, 0, 0, 0, 9'd1));
    td.push_back(mk(0, 1, 32'hC0000001, 1, 1, 8'h01, 32'hC0000001, 0, 0, 0, 0, 9'd2));
    td.push_back(mk(0, 1, 32'hC0000002, 1, 1, 8'h02, 32'hC0000002, 0, 0, 0, 0, 9'd3));
    td.push_back(mk(0, 1, 32'hC0000003, 0, 1, 8'h03, 32'hC0000003, 0, 0, 0, 0, 9'd4));
    td.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 8'h03, 32'hC0000003, 1, 1, 0, 0, 9'd4));
    td.push_back(mk(0, 0, 32'h0,        0, 0, 8'h03, 32'hC0000003, 1, 1, 0, 0, 9'd4));

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = 32'h0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 32'h0;
    #3;
    check_vec(1'b0, zero, "reset_a");
    check_vec(1'b1, zero, "reset_b");
    @(negedge clk);
    rst = 1'b0;

    foreach (ta[i]) apply(1'b0, ta[i], $sformatf("load%0d", i));
    chk("load.mem0", mem_a[0], 32'h20080005);
    chk("load.mem1", mem_a[1], 32'h20090007);
    chk("load.mem2", mem_a[2], 32'h01095020);
    chk("load.we_pulses", 32'(we_cnt_a), 32'd3);

    // running was seen high after the RUN-entry edge; count the remaining cycles.
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    run_cnt = 1;
    fell = 1'b0;
    for (int c = 0; c < 100 && !fell; c++) begin
      @(posedge clk);
      #1;
      if (running_a) run_cnt++;
      else fell = 1'b1;
    end
    chk("run.fell", 32'(fell), 32'd1);
    chk("run.cycles", 32'(run_cnt), 32'd50);
    chk("run.done", 32'(done_a), 32'd1);
    chk("run.running", 32'(running_a), 32'd0);
    chk("run.core_rstn", 32'(rstn_a), 32'd1);
    chk("run.in_ready", 32'(bus_a.in_ready), 32'd0);

    foreach (tb[i]) apply(1'b0, tb[i], $sformatf("err%0d", i));

    // Asynchronous reset mid-load: outputs clear before any clock edge.
    #1;
    rst = 1'b1;
    #1;
    check_vec(1'b0, zero, "midrst");
    #2;
    rst = 1'b0;

    foreach (tc[i]) apply(1'b0, tc[i], $sformatf("reload%0d", i));
    chk("reload.mem0", mem_a[0], 32'hBBBB0001);
    chk("reload.mem1", mem_a[1], 32'h20090007);
    chk("reload.mem2", mem_a[2], 32'h01095020);
    chk("reload.we_pulses", 32'(we_cnt_a), 32'd5);
    @(negedge clk);
    start_a = 1'b0;

    foreach (td[i]) apply(1'b1, td[i], $sformatf("full%0d", i));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full.mem%0d", k), mem_b[k], 32'hC0000000 + 32'(k));
    end
    chk("full.we_pulses", 32'(we_cnt_b), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
